// File: rtl/visor_resta_7seg.sv
// Display stage for a 4-bit add/subtract result. It captures {Cout,Rest} and sel, finds the sign and magnitude, and converts to decimal by repeated subtract-10.
// It drives a 3-digit multiplexed 7-segment display (sign, tens, units). Optional macro LEAD_ZERO_BLANK_EN blanks a zero tens digit.
module visor_resta_7seg #(
    parameter int REFRESH_W = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic       sel,
    input  logic       Cout,
    input  logic [3:0] Rest,
    output logic       ready,
    output logic       busy,
    output logic       neg,
    output logic [2:0] an,
    output logic [6:0] seg
);

    typedef enum logic [1:0] {IDLE, CONV, SHOW} state_t;

    state_t               state;
    logic [4:0]           mag;
    logic [1:0]           tens;
    logic [REFRESH_W-1:0] refresh_cnt;
    logic [1:0]           idx;

    logic                 show_next;
    logic [6:0]           tens_seg;
    logic [6:0]           units_seg;
    logic [6:0]           digit_seg;

    function automatic logic [6:0] glyph(input logic [3:0] v);
        logic [6:0] g;
        case (v)
            4'd0:    g = 7'h40;
            4'd1:    g = 7'h79;
            4'd2:    g = 7'h24;
            4'd3:    g = 7'h30;
            4'd4:    g = 7'h19;
            4'd5:    g = 7'h12;
            4'd6:    g = 7'h02;
            4'd7:    g = 7'h78;
            4'd8:    g = 7'h00;
            4'd9:    g = 7'h10;
            default: g = 7'h7F;
        endcase
        return g;
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            mag   <= 5'd0;
            tens  <= 2'd0;
            neg   <= 1'b0;
            busy  <= 1'b0;
            ready <= 1'b1;
        end else begin
            case (state)
                IDLE, SHOW: begin
                    if (load) begin
                        state <= CONV;
                        busy  <= 1'b1;
                        ready <= 1'b0;
                        tens  <= 2'd0;
                        if (!sel) begin
                            mag <= {Cout, Rest};
                            neg <= 1'b0;
                        end else if (Cout) begin
                            mag <= {1'b0, Rest};
                            neg <= 1'b0;
                        end else begin
                            // Borrow out: two's-complement negate; Rest=0 yields 16
                            mag <= {1'b0, ~Rest} + 5'd1;
                            neg <= 1'b1;
                        end
                    end
                end
                CONV: begin
                    if (mag >= 5'd10) begin
                        mag  <= mag - 5'd10;
                        tens <= tens + 2'd1;
                    end else begin
                        state <= SHOW;
                        busy  <= 1'b0;
                        ready <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    ready <= 1'b1;
                end
            endcase
        end
    end

    // Display follows the next state so it blanks on the same edge a conversion starts
    assign show_next = ((state == SHOW) && !load) || ((state == CONV) && (mag < 5'd10));

`ifdef LEAD_ZERO_BLANK_EN
    assign tens_seg = (tens == 2'd0) ? 7'h7F : glyph({2'b00, tens});
`else
    assign tens_seg = glyph({2'b00, tens});
`endif

    assign units_seg = glyph(mag[3:0]);

    always_comb begin
        digit_seg = 7'h7F;
        case (idx)
            2'd2:    digit_seg = neg ? 7'b0111111 : 7'h7F;
            2'd1:    digit_seg = tens_seg;
            2'd0:    digit_seg = units_seg;
            default: digit_seg = 7'h7F;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            refresh_cnt <= '0;
            idx         <= 2'd0;
            an          <= 3'b111;
            seg         <= 7'h7F;
        end else begin
            refresh_cnt <= refresh_cnt + 1'b1;
            if (&refresh_cnt)
                idx <= (idx == 2'd2) ? 2'd0 : idx + 2'd1;
            if (show_next) begin
                an  <= ~(3'b001 << idx);
                seg <= digit_seg;
            end else begin
                an  <= 3'b111;
                seg <= 7'h7F;
            end
        end
    end

endmodule

// File: tb/tb_visor_resta_7seg.sv
// Directed bench for visor_resta_7seg with a short refresh counter so that digit scanning is fast.
module tb_visor_resta_7seg;

    logic       clk = 1'b0;
    logic       rst;
    logic       load;
    logic       sel;
    logic       Cout;
    logic [3:0] Rest;
    logic       ready;
    logic       busy;
    logic       neg;
    logic [2:0] an;
    logic [6:0] seg;

    int tests = 0;
    int fails = 0;

    localparam logic [6:0] BLANK = 7'h7F;
    localparam logic [6:0] MINUS = 7'b0111111;
`ifdef LEAD_ZERO_BLANK_EN
    localparam logic [6:0] TENS0 = 7'h7F;
`else
    localparam logic [6:0] TENS0 = 7'h40;
`endif

    visor_resta_7seg #(.REFRESH_W(2)) dut (
        .clk   (clk),
        .rst   (rst),
        .load  (load),
        .sel   (sel),
        .Cout  (Cout),
        .Rest  (Rest),
        .ready (ready),
        .busy  (busy),
        .neg   (neg),
        .an    (an),
        .seg   (seg)
    );

    always #5 clk = ~clk;

    // Returns at the falling edge just after the capture edge
    task automatic do_load(input logic s, input logic c, input logic [3:0] r);
        @(negedge clk);
        sel  = s;
        Cout = c;
        Rest = r;
        load = 1'b1;
        @(negedge clk);
        load = 1'b0;
    endtask

    task automatic wait_ready(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (ready === 1'b1) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic grab(output logic [6:0] d2, output logic [6:0] d1, output logic [6:0] d0);
        d2 = 'x;
        d1 = 'x;
        d0 = 'x;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            case (an)
                3'b011:  d2 = seg;
                3'b101:  d1 = seg;
                3'b110:  d0 = seg;
                default: ;
            endcase
        end
    endtask

    task automatic test_reset;
        rst  = 1'b1;
        load = 1'b0;
        sel  = 1'b0;
        Cout = 1'b0;
        Rest = 4'd0;
        #1;
        tests++;
        if ({an, seg} !== {3'b111, BLANK}) begin
            fails++;
            $display("FAIL reset_display: got an=%b seg=%h expected an=111 seg=7f", an, seg);
        end
        tests++;
        if ({neg, busy, ready} !== 3'b001) begin
            fails++;
            $display("FAIL reset_flags: got neg/busy/ready=%b expected 001", {neg, busy, ready});
        end
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (10) @(negedge clk);
        tests++;
        if ({an, ready, busy} !== 5'b11110) begin
            fails++;
            $display("FAIL idle_blank: got an=%b ready=%b busy=%b expected an=111 ready=1 busy=0", an, ready, busy);
        end
    endtask

    task automatic test_sub_pos;
        logic [6:0] d2, d1, d0;
        bit ok;
        do_load(1'b1, 1'b1, 4'd5);
        tests++;
        if ({busy, ready, neg} !== 3'b100) begin
            fails++;
            $display("FAIL pos_conv_flags: got busy/ready/neg=%b expected 100", {busy, ready, neg});
        end
        @(negedge clk);
        tests++;
        if ({busy, ready} !== 2'b01) begin
            fails++;
            $display("FAIL pos_busy_one_clk: got busy/ready=%b expected 01", {busy, ready});
        end
        wait_ready(ok);
        grab(d2, d1, d0);
        tests++;
        if ({d2, d1, d0} !== {BLANK, TENS0, 7'h12}) begin
            fails++;
            $display("FAIL pos_digits: got %h %h %h expected %h %h 12", d2, d1, d0, BLANK, TENS0);
        end
    endtask

    task automatic test_sub_neg;
        logic [6:0] d2, d1, d0;
        bit ok;
        do_load(1'b1, 1'b0, 4'b1101);
        wait_ready(ok);
        tests++;
        if (!ok || neg !== 1'b1) begin
            fails++;
            $display("FAIL neg_flag: got ready_seen=%0d neg=%b expected 1 1", ok, neg);
        end
        grab(d2, d1, d0);
        tests++;
        if ({d2, d1, d0} !== {MINUS, TENS0, 7'h30}) begin
            fails++;
            $display("FAIL neg_digits: got %h %h %h expected 3f %h 30", d2, d1, d0, TENS0);
        end
    endtask

    task automatic test_max_latency;
        logic [6:0] d2, d1, d0;
        int  cnt;
        bit  blank_ok;
        cnt      = 0;
        blank_ok = 1'b1;
        do_load(1'b0, 1'b1, 4'hF);
        for (int i = 0; i < 20; i++) begin
            if (busy !== 1'b1) break;
            cnt++;
            if (an !== 3'b111 || seg !== BLANK) blank_ok = 1'b0;
            @(negedge clk);
        end
        tests++;
        if (cnt != 4) begin
            fails++;
            $display("FAIL max_busy_cycles: got %0d expected 4", cnt);
        end
        tests++;
        if (!blank_ok) begin
            fails++;
            $display("FAIL conv_blank: got non-blank display during CONV expected an=111 seg=7f");
        end
        grab(d2, d1, d0);
        tests++;
        if ({d2, d1, d0} !== {BLANK, 7'h30, 7'h79}) begin
            fails++;
            $display("FAIL max_digits: got %h %h %h expected 7f 30 79", d2, d1, d0);
        end
    endtask

    task automatic test_minus16_ignore_load;
        logic [6:0] d2, d1, d0;
        bit ok;
        do_load(1'b1, 1'b0, 4'd0);
        tests++;
        if (ready !== 1'b0) begin
            fails++;
            $display("FAIL m16_ready_low: got %b expected 0", ready);
        end
        sel  = 1'b0;
        Cout = 1'b0;
        Rest = 4'd3;
        load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        wait_ready(ok);
        grab(d2, d1, d0);
        tests++;
        if ({neg, d2, d1, d0} !== {1'b1, MINUS, 7'h79, 7'h02}) begin
            fails++;
            $display("FAIL m16_digits: got neg=%b %h %h %h expected neg=1 3f 79 02", neg, d2, d1, d0);
        end
    endtask

    task automatic test_scan_seven;
        logic [6:0] d2, d1, d0;
        logic [2:0] prev, v;
        bit ok, scan_ok, found;
        do_load(1'b0, 1'b0, 4'd7);
        wait_ready(ok);
        grab(d2, d1, d0);
        tests++;
        if ({neg, d2, d1, d0} !== {1'b0, BLANK, TENS0, 7'h78}) begin
            fails++;
            $display("FAIL seven_digits: got neg=%b %h %h %h expected neg=0 7f %h 78", neg, d2, d1, d0, TENS0);
        end
        found = 1'b0;
        prev  = an;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (an !== prev) begin
                found = 1'b1;
                break;
            end
        end
        v       = an;
        scan_ok = found && (v == 3'b110 || v == 3'b101 || v == 3'b011);
        for (int k = 0; k < 12; k++) begin
            if (k > 0) begin
                @(negedge clk);
                if (k % 4 == 0) v = {v[1:0], v[2]};
            end
            if (an !== v) scan_ok = 1'b0;
        end
        tests++;
        if (!scan_ok) begin
            fails++;
            $display("FAIL scan_order: got an=%b expected %b with 110->101->011 every 4 clk", an, v);
        end
    endtask

    task automatic test_reset_mid_conv;
        bit idle_ok;
        do_load(1'b0, 1'b1, 4'hF);
        tests++;
        if (busy !== 1'b1) begin
            fails++;
            $display("FAIL midconv_busy: got %b expected 1", busy);
        end
        #1;
        rst = 1'b1;
        #1;
        tests++;
        if ({an, seg, neg, ready, busy} !== {3'b111, BLANK, 3'b010}) begin
            fails++;
            $display("FAIL midconv_reset: got an=%b seg=%h neg=%b ready=%b busy=%b expected 111 7f 0 1 0",
                     an, seg, neg, ready, busy);
        end
        @(negedge clk);
        rst     = 1'b0;
        idle_ok = 1'b1;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            if (an !== 3'b111 || ready !== 1'b1 || busy !== 1'b0) idle_ok = 1'b0;
        end
        tests++;
        if (!idle_ok) begin
            fails++;
            $display("FAIL midconv_idle: got an=%b ready=%b busy=%b expected 111 1 0", an, ready, busy);
        end
    endtask

    initial begin
        test_reset;
        test_sub_pos;
        test_sub_neg;
        test_max_latency;
        test_minus16_ignore_load;
        test_scan_seven;
        test_reset_mid_conv;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
